fetch_top: RTL and testbench

- Instruction fetch stage; sits directly upstream of decode.
- Holds the PC and issues one word request at a time to the instruction cache.
- Buffers each returned instruction in a one-entry output register that feeds decode (fetch_instr_valid/data/pc, xcpt_fetch).
- Applies branch and exception redirects, kills the in-flight response on redirect, and flags misaligned PCs as a fetch exception.

---
 rtl/fetch_top_if.sv | 21 ++
 rtl/fetch_top.sv | 136 +++++++++++++
 tb/tb_fetch_top.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_top_if.sv
// Instruction-cache request/response bus between the fetch stage (master) and the cache (slave).
interface fetch_top_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   icache_req_valid;
    logic [PC_WIDTH-1:0]    icache_req_addr;
    logic                   icache_req_ready;
    logic                   icache_rsp_valid;
    logic [INSTR_WIDTH-1:0] icache_rsp_data;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_ready, icache_rsp_valid, icache_rsp_data
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_ready, icache_rsp_valid, icache_rsp_data
    );
endinterface

// File: rtl/fetch_top.sv
// Instruction fetch stage: one outstanding icache request, a one-entry output buffer
// towards decode, branch/exception redirects and misaligned-PC fetch exceptions.
module fetch_top #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    BOOT_PC     = 32'h0000_1000,
    parameter logic [PC_WIDTH-1:0]    XCPT_PC     = 32'h0000_2000,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall_fetch,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_pc,
    input  logic                   xcpt_redirect,
    fetch_top_if.master            icache,
    output logic                   fetch_instr_valid,
    output logic [INSTR_WIDTH-1:0] fetch_instr_data,
    output logic [PC_WIDTH-1:0]    fetch_instr_pc,
    output logic                   xcpt_fetch_valid,
    output logic [PC_WIDTH-1:0]    xcpt_fetch_pc
);
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e                 state_ff, state_nxt;
    logic [PC_WIDTH-1:0]    pc_ff, pc_nxt;
    logic                   kill_ff, kill_nxt;
    logic                   buf_valid_ff, buf_valid_nxt;
    logic                   buf_xcpt_ff, buf_xcpt_nxt;
    logic [INSTR_WIDTH-1:0] buf_data_ff, buf_data_nxt;
    logic [PC_WIDTH-1:0]    buf_pc_ff, buf_pc_nxt;

    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   buf_free;
    logic                   misaligned;
    logic                   req_valid;

    assign redirect    = xcpt_redirect | branch_taken;
    assign redirect_pc = xcpt_redirect ? XCPT_PC : branch_pc;
    assign buf_free    = !buf_valid_ff || !stall_fetch;
    assign misaligned  = pc_ff[1:0] != 2'b00;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt     = state_ff;
        pc_nxt        = pc_ff;
        kill_nxt      = kill_ff;
        buf_valid_nxt = buf_valid_ff && stall_fetch;
        buf_xcpt_nxt  = buf_xcpt_ff;
        buf_data_nxt  = buf_data_ff;
        buf_pc_nxt    = buf_pc_ff;
        req_valid     = 1'b0;

        if (redirect) begin
            // A response landing in the redirect cycle is dropped; only a still-pending one needs a kill.
            pc_nxt        = redirect_pc;
            buf_valid_nxt = 1'b0;
            if (state_ff == WAIT && !icache.icache_rsp_valid) begin
                kill_nxt = 1'b1;
            end else begin
                kill_nxt  = 1'b0;
                state_nxt = REQ;
            end
        end else begin
            case (state_ff)
                REQ: begin
                    if (misaligned) begin
                        if (buf_free) begin
                            buf_valid_nxt = 1'b1;
                            buf_xcpt_nxt  = 1'b1;
                            buf_data_nxt  = NOP_INSTR;
                            buf_pc_nxt    = pc_ff;
                            state_nxt     = HALT;
                        end
                    end else begin
                        req_valid = buf_free;
                        if (buf_free && icache.icache_req_ready) begin
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (icache.icache_rsp_valid) begin
                        if (!kill_ff) begin
                            buf_valid_nxt = 1'b1;
                            buf_xcpt_nxt  = 1'b0;
                            buf_data_nxt  = icache.icache_rsp_data;
                            buf_pc_nxt    = pc_ff;
                            pc_nxt        = pc_ff + PC_WIDTH'(4);
                        end
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end
                end
                HALT:    state_nxt = HALT;
                default: state_nxt = REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_ff     <= REQ;
            pc_ff        <= BOOT_PC;
            kill_ff      <= 1'b0;
            buf_valid_ff <= 1'b0;
            buf_xcpt_ff  <= 1'b0;
            // NOTE: the buffer payload is reset too because decode-facing outputs must read zero.
            buf_data_ff  <= '0;
            buf_pc_ff    <= '0;
        end else begin
            state_ff     <= state_nxt;
            pc_ff        <= pc_nxt;
            kill_ff      <= kill_nxt;
            buf_valid_ff <= buf_valid_nxt;
            buf_xcpt_ff  <= buf_xcpt_nxt;
            buf_data_ff  <= buf_data_nxt;
            buf_pc_ff    <= buf_pc_nxt;
        end
    end

    assign icache.icache_req_valid = req_valid && !reset;
    assign icache.icache_req_addr  = pc_ff;

    assign fetch_instr_valid = buf_valid_ff;
    assign fetch_instr_data  = buf_data_ff;
    assign fetch_instr_pc    = buf_pc_ff;
    assign xcpt_fetch_valid  = buf_valid_ff && buf_xcpt_ff;
    assign xcpt_fetch_pc     = buf_pc_ff;
endmodule

// File: tb/tb_fetch_top.sv
// Self-checking bench for fetch_top: directed scenarios plus a randomized run against a
// transaction-level model (expected instruction stream) and a behavioural icache.
module tb_fetch_top;
    localparam logic [31:0] BOOT_PC   = 32'h0000_1000;
    localparam logic [31:0] XCPT_PC   = 32'h0000_2000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_fetch;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic        xcpt_redirect;
    logic        fetch_instr_valid;
    logic [31:0] fetch_instr_data;
    logic [31:0] fetch_instr_pc;
    logic        xcpt_fetch_valid;
    logic [31:0] xcpt_fetch_pc;

    fetch_top_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) icache ();

    fetch_top dut (
        .clock             (clock),
        .reset             (reset),
        .stall_fetch       (stall_fetch),
        .branch_taken      (branch_taken),
        .branch_pc         (branch_pc),
        .xcpt_redirect     (xcpt_redirect),
        .icache            (icache.master),
        .fetch_instr_valid (fetch_instr_valid),
        .fetch_instr_data  (fetch_instr_data),
        .fetch_instr_pc    (fetch_instr_pc),
        .xcpt_fetch_valid  (xcpt_fetch_valid),
        .xcpt_fetch_pc     (xcpt_fetch_pc)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural icache: one pending request, answered after lat cycles.
    logic        rdy;
    int          lat;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_dly;

    // Outputs sampled at the falling edge of the most recent cycle.
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_valid;
    logic [31:0] s_data;
    logic [31:0] s_pc;
    logic        s_xv;
    logic [31:0] s_xpc;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    task automatic set_in(input bit st, input bit br, input logic [31:0] bpc, input bit xr, input bit rd);
        stall_fetch   = st;
        branch_taken  = br;
        branch_pc     = bpc;
        xcpt_redirect = xr;
        rdy           = rd;
    endtask

    // One clock cycle: drive cache inputs, sample at negedge, advance the cache after posedge.
    task automatic cycle();
        bit fire;
        fire = pend && (pend_dly == 0);
        icache.icache_req_ready = rdy;
        icache.icache_rsp_valid = fire;
        icache.icache_rsp_data  = fire ? mem_word(pend_addr) : $urandom;
        @(negedge clock);
        s_req_valid = icache.icache_req_valid;
        s_req_addr  = icache.icache_req_addr;
        s_valid     = fetch_instr_valid;
        s_data      = fetch_instr_data;
        s_pc        = fetch_instr_pc;
        s_xv        = xcpt_fetch_valid;
        s_xpc       = xcpt_fetch_pc;
        @(posedge clock);
        #1;
        if (fire) pend = 1'b0;
        else if (pend && pend_dly > 0) pend_dly--;
        if (s_req_valid && rdy) begin
            pend      = 1'b1;
            pend_addr = s_req_addr;
            pend_dly  = lat - 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 32'h0, 0, 1);
        lat  = 1;
        pend = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({s_valid, s_xv, s_req_valid} !== 3'b000)
            $display("FAIL reset_valids got %b exp 000", {s_valid, s_xv, s_req_valid});
        else pass_cnt++;
        total_cnt++;
        if (s_data !== 32'h0) $display("FAIL reset_data got %h exp 00000000", s_data);
        else pass_cnt++;
        total_cnt++;
        if ({s_pc, s_xpc} !== 64'h0) $display("FAIL reset_pcs got %h/%h exp 0/0", s_pc, s_xpc);
        else pass_cnt++;
        total_cnt++;
        if (s_req_addr !== BOOT_PC) $display("FAIL reset_req_addr got %h exp %h", s_req_addr, BOOT_PC);
        else pass_cnt++;
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            cycle();
            if (c == 0) begin
                total_cnt++;
                if ({s_req_valid, s_req_addr} !== {1'b1, BOOT_PC})
                    $display("FAIL seq_first_req got %b/%h exp 1/%h", s_req_valid, s_req_addr, BOOT_PC);
                else pass_cnt++;
            end
            if (c == 2 || c == 4 || c == 6) begin
                e = BOOT_PC + 32'((c / 2 - 1) * 4);
                total_cnt++;
                if ({s_valid, s_pc, s_data, s_xv} !== {1'b1, e, mem_word(e), 1'b0})
                    $display("FAIL seq_out_c%0d got %b/%h/%h exp 1/%h/%h", c, s_valid, s_pc, s_data, e, mem_word(e));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            stall_fetch = (c >= 4 && c <= 8);
            cycle();
            if (c >= 4 && c <= 8) begin
                total_cnt++;
                if ({s_valid, s_pc, s_data, s_req_valid} !== {1'b1, 32'h1004, mem_word(32'h1004), 1'b0})
                    $display("FAIL stall_hold_c%0d got %b/%h/%h req %b exp 1/00001004/%h req 0",
                             c, s_valid, s_pc, s_data, s_req_valid, mem_word(32'h1004));
                else pass_cnt++;
            end
            if (c == 9) begin
                total_cnt++;
                if ({s_req_valid, s_req_addr} !== {1'b1, 32'h1008})
                    $display("FAIL stall_release_req got %b/%h exp 1/00001008", s_req_valid, s_req_addr);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            lat = (c == 4) ? 4 : 1;
            set_in(0, c == 5, 32'h3000, 0, 1);
            cycle();
            if (c == 4) begin
                total_cnt++;
                if ({s_req_valid, s_req_addr} !== {1'b1, 32'h1008})
                    $display("FAIL redir_req1008 got %b/%h exp 1/00001008", s_req_valid, s_req_addr);
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++;
                if (s_req_valid !== 1'b0) $display("FAIL redir_cycle_req got %b exp 0", s_req_valid);
                else pass_cnt++;
            end
            if (c >= 6 && c <= 10) begin
                total_cnt++;
                if (s_valid !== 1'b0) $display("FAIL redir_killed_c%0d got valid %b pc %h exp valid 0", c, s_valid, s_pc);
                else pass_cnt++;
            end
            if (c == 9) begin
                total_cnt++;
                if ({s_req_valid, s_req_addr} !== {1'b1, 32'h3000})
                    $display("FAIL redir_target_req got %b/%h exp 1/00003000", s_req_valid, s_req_addr);
                else pass_cnt++;
            end
            if (c == 11) begin
                total_cnt++;
                if ({s_valid, s_pc, s_data} !== {1'b1, 32'h3000, mem_word(32'h3000)})
                    $display("FAIL redir_out got %b/%h/%h exp 1/00003000/%h", s_valid, s_pc, s_data, mem_word(32'h3000));
                else pass_cnt++;
            end
        end
        set_in(0, 0, 32'h0, 0, 1);
    endtask

    task automatic test_misaligned();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            set_in(0, c == 0, 32'h3002, c == 6, c != 0);
            cycle();
            if (c == 1 || (c >= 3 && c <= 6)) begin
                total_cnt++;
                if (s_req_valid !== 1'b0) $display("FAIL misal_no_req_c%0d got %b exp 0", c, s_req_valid);
                else pass_cnt++;
            end
            if (c == 2) begin
                total_cnt++;
                if ({s_valid, s_xv, s_xpc, s_pc, s_data, s_req_valid} !== {2'b11, 32'h3002, 32'h3002, NOP_INSTR, 1'b0})
                    $display("FAIL misal_xcpt got v%b x%b xpc %h pc %h data %h req %b exp v1 x1 xpc 00003002 pc 00003002 data %h req 0",
                             s_valid, s_xv, s_xpc, s_pc, s_data, s_req_valid, NOP_INSTR);
                else pass_cnt++;
            end
            if (c == 7) begin
                total_cnt++;
                if ({s_req_valid, s_req_addr} !== {1'b1, XCPT_PC})
                    $display("FAIL misal_xcpt_req got %b/%h exp 1/%h", s_req_valid, s_req_addr, XCPT_PC);
                else pass_cnt++;
            end
        end
        set_in(0, 0, 32'h0, 0, 1);
    endtask

    task automatic test_priority();
        do_reset();
        set_in(0, 1, 32'h4000, 1, 0);
        cycle();
        total_cnt++;
        if (s_req_valid !== 1'b0) $display("FAIL prio_redirect_cycle got %b exp 0", s_req_valid);
        else pass_cnt++;
        set_in(0, 0, 32'h0, 0, 0);
        cycle();
        total_cnt++;
        if ({s_req_valid, s_req_addr} !== {1'b1, XCPT_PC})
            $display("FAIL prio_req got %b/%h exp 1/%h", s_req_valid, s_req_addr, XCPT_PC);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            lat   = (c == 8) ? 3 : 1;
            reset = (c == 9 || c == 10);
            rdy   = (c != 11);
            cycle();
            if (c == 8) begin
                total_cnt++;
                if ({s_req_valid, s_req_addr} !== {1'b1, 32'h1010})
                    $display("FAIL rstw_req1010 got %b/%h exp 1/00001010", s_req_valid, s_req_addr);
                else pass_cnt++;
            end
            if (c == 10) begin
                total_cnt++;
                if ({s_valid, s_xv, s_req_valid, s_data, s_pc, s_xpc, s_req_addr} !== {3'b000, 96'h0, BOOT_PC})
                    $display("FAIL rstw_outputs got v%b x%b r%b %h %h %h addr %h exp all 0 addr %h",
                             s_valid, s_xv, s_req_valid, s_data, s_pc, s_xpc, s_req_addr, BOOT_PC);
                else pass_cnt++;
            end
            if (c == 11 || c == 12) begin
                total_cnt++;
                if ({s_valid, s_req_valid, s_req_addr} !== {2'b01, BOOT_PC})
                    $display("FAIL rstw_late_rsp_c%0d got v%b req %b/%h exp v0 req 1/%h", c, s_valid, s_req_valid, s_req_addr, BOOT_PC);
                else pass_cnt++;
            end
            if (c == 14) begin
                total_cnt++;
                if ({s_valid, s_pc, s_data} !== {1'b1, BOOT_PC, mem_word(BOOT_PC)})
                    $display("FAIL rstw_out got %b/%h/%h exp 1/%h/%h", s_valid, s_pc, s_data, BOOT_PC, mem_word(BOOT_PC));
                else pass_cnt++;
            end
        end
    endtask

    // The model is the architectural instruction stream: consumed entries must follow
    // exp_pc sequentially (wrapping), restarting at each redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          consumed;
        int          r;
        do_reset();
        exp_pc   = BOOT_PC;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(99, 0));
            lat = int'($urandom_range(3, 1));
            set_in($urandom_range(9, 0) < 3, r >= 1 && r < 6,
                   ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC),
                   r < 1, $urandom_range(9, 0) < 7);
            cycle();
            if (s_valid && !stall_fetch) begin
                total_cnt++;
                if ({s_pc, s_data, s_xv} !== {exp_pc, mem_word(exp_pc), 1'b0})
                    $display("FAIL rand_consume got %h/%h x%b exp %h/%h x0", s_pc, s_data, s_xv, exp_pc, mem_word(exp_pc));
                else pass_cnt++;
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            total_cnt++;
            if (s_req_valid && (branch_taken || xcpt_redirect || (s_valid && stall_fetch)))
                $display("FAIL rand_req_gating got req 1 exp 0 (redirect %b stall %b valid %b)",
                         branch_taken | xcpt_redirect, stall_fetch, s_valid);
            else pass_cnt++;
            if (xcpt_redirect) exp_pc = XCPT_PC;
            else if (branch_taken) exp_pc = branch_pc;
        end
        total_cnt++;
        if (consumed < 100) $display("FAIL rand_progress got %0d exp >= 100", consumed);
        else pass_cnt++;
        set_in(0, 0, 32'h0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_inflight();
        test_misaligned();
        test_priority();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
